// File: rtl/pong_pkg.sv
// Shared Pong datapath definitions: game state, coordinate type and field geometry
// used by collision_detect, ball_movement and the paddle controller.
package pong_pkg;

    localparam int P_COORD_W     = 6;
    localparam int P_FIELD_W     = 64;
    localparam int P_FIELD_H     = 64;
    localparam int P_PADDLE_H    = 8;
    localparam int P_LEFT_PAD_X  = 2;
    localparam int P_RIGHT_PAD_X = 61;

    typedef logic [P_COORD_W-1:0] coord_t;

    typedef enum logic [1:0] {
        SERVE,
        PLAY,
        GAME_OVER
    } state_t;

endpackage

// File: rtl/pong_tick_timer.sv
// Loadable down-counter stepped by the frame tick; stops at zero.
// A load wins over a decrement in the same cycle.
module pong_tick_timer #(
    parameter int             W       = 6,
    parameter logic [W-1:0]   RST_VAL = '0
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         tick,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic [W-1:0] count
);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            count <= RST_VAL;
        else if (load)
            count <= load_val;
        else if (tick && count != '0)
            count <= count - W'(1);
    end

endmodule

// File: rtl/collision_detect.sv
// Pong collision/scoring stage: wall and paddle reflection pulses, point pulses,
// score keeping and serve-hold / game-over sequencing, all evaluated on tick.
module collision_detect
    import pong_pkg::*;
#(
    parameter int COORD_W     = P_COORD_W,
    parameter int FIELD_W     = P_FIELD_W,
    parameter int FIELD_H     = P_FIELD_H,
    parameter int PADDLE_H    = P_PADDLE_H,
    parameter int LEFT_PAD_X  = P_LEFT_PAD_X,
    parameter int RIGHT_PAD_X = P_RIGHT_PAD_X,
    parameter int LOCKOUT     = 4,
    parameter int SERVE_DELAY = 60,
    parameter int SCORE_W     = 4,
    parameter int WIN_SCORE   = 9
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               tick,
    input  logic               start,
    input  logic [COORD_W-1:0] bx,
    input  logic [COORD_W-1:0] by,
    input  logic               bx_dir,
    input  logic               by_dir,
    input  logic [COORD_W-1:0] p1_y,
    input  logic [COORD_W-1:0] p2_y,
    output logic               paddle_collision,
    output logic               wall_collision,
    output logic               sc1,
    output logic               sc2,
    output logic [SCORE_W-1:0] score1,
    output logic [SCORE_W-1:0] score2,
    output logic               serve_hold,
    output logic               game_over
);

    localparam int SRV_W = $clog2(SERVE_DELAY + 1);
    localparam int LO_W  = $clog2(LOCKOUT + 1);

    localparam logic [COORD_W-1:0] L_HIT_X  = COORD_W'(LEFT_PAD_X + 1);
    localparam logic [COORD_W-1:0] R_HIT_X  = COORD_W'(RIGHT_PAD_X - 1);
    localparam logic [COORD_W-1:0] X_MAX    = COORD_W'(FIELD_W - 1);
    localparam logic [COORD_W-1:0] Y_MAX    = COORD_W'(FIELD_H - 1);
    localparam logic [COORD_W:0]   PAD_SPAN = (COORD_W+1)'(PADDLE_H - 1);
    localparam logic [SCORE_W-1:0] WIN      = SCORE_W'(WIN_SCORE);
    localparam logic [LO_W-1:0]    LO_MAX   = LO_W'(LOCKOUT);

    state_t state, state_n;

    logic [SRV_W-1:0]           serve_cnt;
    logic                       serve_load;
    // index 0 = wall lockout, index 1 = paddle lockout
    logic [1:0][LO_W-1:0]       lo_cnt;
    logic [1:0][LO_W-1:0]       lo_val;
    logic [1:0]                 lo_load;

    logic [SCORE_W-1:0] s1_n, s2_n;
    logic eval, miss_l, miss_r, miss, wall_hit, left_hit, right_hit;
    logic fire_wall, fire_pad, pt1, pt2;

    pong_tick_timer #(.W(SRV_W), .RST_VAL(SRV_W'(SERVE_DELAY))) u_serve (
        .clk      (clk),
        .reset    (reset),
        .tick     (tick),
        .load     (serve_load),
        .load_val (SRV_W'(SERVE_DELAY)),
        .count    (serve_cnt)
    );

    for (genvar i = 0; i < 2; i++) begin : g_lockout
        pong_tick_timer #(.W(LO_W)) u_lo (
            .clk      (clk),
            .reset    (reset),
            .tick     (tick),
            .load     (lo_load[i]),
            .load_val (lo_val[i]),
            .count    (lo_cnt[i])
        );
    end

    // Paddle bottom edge is formed one bit wider so a paddle near y=63 clips instead of wrapping.
    always_comb begin
        eval      = tick && (state == PLAY);
        miss_l    = (bx == '0) && !bx_dir;
        miss_r    = (bx == X_MAX) && bx_dir;
        miss      = miss_l || miss_r;
        wall_hit  = ((by == '0) && !by_dir) || ((by == Y_MAX) && by_dir);
        left_hit  = (bx == L_HIT_X) && !bx_dir && (by >= p1_y) &&
                    ({1'b0, by} <= {1'b0, p1_y} + PAD_SPAN);
        right_hit = (bx == R_HIT_X) && bx_dir && (by >= p2_y) &&
                    ({1'b0, by} <= {1'b0, p2_y} + PAD_SPAN);
        fire_wall = eval && wall_hit && (lo_cnt[0] == '0) && !miss;
        fire_pad  = eval && (left_hit || right_hit) && (lo_cnt[1] == '0) && !miss;
        pt1       = eval && miss_r;
        pt2       = eval && miss_l;
    end

    always_comb begin
        state_n    = state;
        s1_n       = score1;
        s2_n       = score2;
        serve_load = 1'b0;
        lo_load    = '0;
        lo_val     = '0;
        unique case (state)
            SERVE: begin
                if (tick && serve_cnt == SRV_W'(1))
                    state_n = PLAY;
            end
            PLAY: begin
                if (pt1 || pt2) begin
                    if (pt1 && score1 != WIN) s1_n = score1 + SCORE_W'(1);
                    if (pt2 && score2 != WIN) s2_n = score2 + SCORE_W'(1);
                    serve_load = 1'b1;
                    lo_load    = 2'b11;
                    state_n    = (s1_n == WIN || s2_n == WIN) ? GAME_OVER : SERVE;
                end else begin
                    if (fire_wall) begin
                        lo_load[0] = 1'b1;
                        lo_val[0]  = LO_MAX;
                    end
                    if (fire_pad) begin
                        lo_load[1] = 1'b1;
                        lo_val[1]  = LO_MAX;
                    end
                end
            end
            GAME_OVER: begin
                if (start) begin
                    s1_n       = '0;
                    s2_n       = '0;
                    serve_load = 1'b1;
                    state_n    = SERVE;
                end
            end
            default: state_n = SERVE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state            <= SERVE;
            paddle_collision <= 1'b0;
            wall_collision   <= 1'b0;
            sc1              <= 1'b0;
            sc2              <= 1'b0;
            score1           <= '0;
            score2           <= '0;
            serve_hold       <= 1'b1;
            game_over        <= 1'b0;
        end else begin
            state            <= state_n;
            paddle_collision <= fire_pad;
            wall_collision   <= fire_wall;
            sc1              <= pt1;
            sc2              <= pt2;
            score1           <= s1_n;
            score2           <= s2_n;
            serve_hold       <= (state_n != PLAY);
            game_over        <= (state_n == GAME_OVER);
        end
    end

endmodule

// File: doc/collision_detect.md
Name: collision_detect

Overview:
- Collision and scoring stage directly upstream of ball_movement in the Pong datapath.
- Each frame tick it compares the current ball position and direction against the field walls and both paddles.
- Emits single-cycle paddle_collision / wall_collision pulses that ball_movement uses to reflect velocity.
- Emits sc1 / sc2 point pulses that recentre the ball, keeps both scores, and runs the serve-hold and game-over sequencing.

Parameters:
- COORD_W, 6, width of ball/paddle coordinates
- FIELD_W, 64, field width in pixels; x in 0..63
- FIELD_H, 64, field height in pixels; y in 0..63
- PADDLE_H, 8, paddle height in pixels
- LEFT_PAD_X, 2, x column of left paddle
- RIGHT_PAD_X, 61, x column of right paddle
- LOCKOUT, 4, ticks a collision type is suppressed after firing
- SERVE_DELAY, 60, ticks of serve hold after a point or start
- SCORE_W, 4, score counter width
- WIN_SCORE, 9, score that ends the game

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- tick  in  1  frame-step strobe, one clk wide; all evaluation happens only on tick
- start  in  1  pulse; begins a new game from GAME_OVER
- bx  in  COORD_W  ball x position
- by  in  COORD_W  ball y position
- bx_dir  in  1  1 = moving right, 0 = moving left
- by_dir  in  1  1 = moving down (+y), 0 = moving up
- p1_y  in  COORD_W  left paddle top y
- p2_y  in  COORD_W  right paddle top y
- paddle_collision  out  1  one-clk pulse; reflect x velocity
- wall_collision  out  1  one-clk pulse; reflect y velocity
- sc1  out  1  one-clk pulse; player 1 (left) scored
- sc2  out  1  one-clk pulse; player 2 (right) scored
- score1  out  SCORE_W  player 1 score
- score2  out  SCORE_W  player 2 score
- serve_hold  out  1  high while the ball must stay centred
- game_over  out  1  high in GAME_OVER

Behaviour:
- Reset values (asserted when reset=0, immediate):
  - state=SERVE, serve counter=SERVE_DELAY.
  - serve_hold=1.
  - All pulses=0, scores=0, game_over=0, both lockout counters=0.
- All outputs are registered. Each pulse is asserted on the clk edge after the tick cycle in which its condition was sampled, for exactly one clk.
- State machine:
  - SERVE: serve_hold=1. On each tick, decrement the serve counter. On the tick where the counter is 1, go to PLAY, and serve_hold=0 on the next clk.
  - PLAY: evaluate the conditions below on each tick.
  - GAME_OVER: game_over=1 and serve_hold=1. All pulses are suppressed and ticks are ignored. On start, clear scores and game_over and enter SERVE with the counter reloaded. start is ignored in every other state.
- Wall condition:
  - Fires when (by==0 and by_dir==0) or (by==FIELD_H-1 and by_dir==1).
  - Direction gating prevents a re-fire once the ball has been reflected.
- Paddle condition:
  - Left hit: bx==LEFT_PAD_X+1, bx_dir==0, and p1_y <= by <= p1_y+PADDLE_H-1.
  - Right hit: bx==RIGHT_PAD_X-1, bx_dir==1, and p2_y <= by <= p2_y+PADDLE_H-1.
  - Compute the upper bound at COORD_W+1 bits; a paddle extending past 63 is clipped, not wrapped.
- Lockout:
  - Each collision type has its own counter, loaded with LOCKOUT when its pulse fires and decremented on each tick.
  - While a counter is nonzero, that condition is ignored.
- Miss:
  - bx==0 with bx_dir==0 gives sc2 and score2+1.
  - bx==FIELD_W-1 with bx_dir==1 gives sc1 and score1+1.
  - After a miss, enter SERVE with the counter reloaded and both lockouts cleared.
  - If the new score equals WIN_SCORE, enter GAME_OVER instead. The sc pulse still fires.
- Simultaneous events on one tick:
  - Wall and paddle both fire together (corner hit).
  - Wall and miss: only the sc pulse fires; the wall pulse is suppressed.
- Scores never exceed WIN_SCORE; no wrap.
- A reset during any state returns everything to the reset values on the same edge.

Decomposition:
- Shared pong_pkg holds:
  - state enum {SERVE, PLAY, GAME_OVER};
  - coordinate typedef (logic [COORD_W-1:0]);
  - field dimensions and paddle column constants, shared with ball_movement and the paddle controller.
- One sub-module, pong_tick_timer: a loadable down-counter that decrements on tick and flags zero.
  - Instantiated three times: serve delay, paddle lockout, wall lockout.

Test Plan:
- Reset low then high with tick every 4 clk -> serve_hold=1 for 60 ticks, then 0. No pulses before PLAY.
- PLAY, bx=30, by=0, by_dir=0, tick -> wall_collision high exactly 1 clk after the tick. A repeat of the same inputs within 4 ticks gives no pulse; on the 5th tick the pulse fires.
- bx=3, bx_dir=0, p1_y=20, by=27 -> paddle_collision. Same with by=28 -> no pulse. p2_y=60, bx=60, bx_dir=1, by=63 -> paddle_collision and wall_collision together.
- bx=63, bx_dir=1 -> sc1 pulse, score1=1, serve_hold=1 for the next 60 ticks.
- score2=8, then bx=0, bx_dir=0 -> sc2, score2=9, game_over=1, further ticks ignored. Pulse start -> scores 0, SERVE.
- Reset asserted mid-lockout and mid-serve -> all outputs at reset values immediately, with no pulse on release.
